// File: rtl/piso_pkg.sv
// Shared encodings and sizing helpers for the parallel-in/serial-out shift controller.
// Imported by the controller and its counter.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_down_cnt.sv
// Loadable down-counter with enable and zero flag; parks at zero instead of wrapping.
// Used for both the bit counter and the inter-word gap counter.
module bit_down_cnt
  import piso_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/piso_shift_ctrl.sv
// Sequences one parallel word out serially (MSB- or LSB-first) with a handshake on input
// and an optional idle gap between words.
module piso_shift_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             lsb_first,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic             dir_reg, dir_next;
  logic             ready_reg, ready_next;
  logic             done_reg, done_next;

  logic             bit_load, bit_en, bit_zero;
  logic             gap_load, gap_en, gap_zero;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] shreg_shifted;

  bit_down_cnt #(.W(BW)) u_bit_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (bit_load),
    .load_val (BIT_LOAD),
    .en       (bit_en),
    .cnt      (bit_cnt),
    .zero     (bit_zero)
  );

  bit_down_cnt #(.W(GW)) u_gap_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (gap_en),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  // Shift toward whichever end feeds sout, filling the vacated end with zero.
  assign shreg_shifted = dir_reg ? {1'b0, shreg_reg[WIDTH-1:1]}
                                 : {shreg_reg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= ST_IDLE;
      shreg_reg <= '0;
      dir_reg   <= 1'b0;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      dir_reg   <= dir_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    dir_next   = dir_reg;
    ready_next = ready_reg;
    done_next  = 1'b0;
    bit_load   = 1'b0;
    bit_en     = 1'b0;
    gap_load   = 1'b0;
    gap_en     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        ready_next = 1'b1;
        if (din_valid && ready_reg) begin
          shreg_next = din;
          dir_next   = lsb_first;
          bit_load   = 1'b1;
          ready_next = 1'b0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (!bit_zero) begin
            shreg_next = shreg_shifted;
            bit_en     = 1'b1;
          end else begin
            done_next = 1'b1;
            // With no gap the controller is ready again alongside the done pulse.
            if (GAP > 0) begin
              gap_load   = 1'b1;
              ready_next = 1'b0;
              state_next = ST_GAP;
            end else begin
              ready_next = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (gap_zero) begin
          ready_next = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        ready_next = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign din_ready  = ready_reg;
  assign done       = done_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign sout_valid = (state_reg == ST_SHIFT);
  assign sout       = (state_reg == ST_SHIFT)
                      ? (dir_reg ? shreg_reg[0] : shreg_reg[WIDTH-1]) : 1'b0;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Directed bench for piso_shift_ctrl: one DUT with GAP=1, one with GAP=0, sharing stimulus.
module tb_piso_shift_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       lsb_first = 1'b0;
  logic       shift_en = 1'b0;

  logic din_ready, sout, sout_valid, busy, done;
  logic din_ready0, sout0, sout_valid0, busy0, done0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_shift_ctrl #(.WIDTH(8), .GAP(1)) dut (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .lsb_first(lsb_first), .shift_en(shift_en), .sout(sout), .sout_valid(sout_valid),
    .busy(busy), .done(done)
  );

  piso_shift_ctrl #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
    .lsb_first(lsb_first), .shift_en(shift_en), .sout(sout0), .sout_valid(sout_valid0),
    .busy(busy0), .done(done0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset both DUTs and leave them in IDLE with din_ready high.
  task automatic do_reset();
    din_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  // Present one word for a single accept edge.
  task automatic send_word(input logic [7:0] d, input logic lsb);
    din = d;
    lsb_first = lsb;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    #2;
    n_checks++;
    if ({din_ready, done, sout, sout_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/done/sout/sv/busy=%b want 00000",
               {din_ready, done, sout, sout_valid, busy});
    end
    tick();
    clr = 1'b0;
    n_checks++;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_low: got %b want 0", din_ready);
    end
    tick();
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: got %b want 1", din_ready);
    end
    $display("test_reset done");
  endtask

  // seq[7] is the first bit expected on sout, seq[0] the last.
  task automatic test_shift_order(input string name, input logic [7:0] d, input logic lsb,
                                  input logic [7:0] seq);
    do_reset();
    shift_en = 1'b1;
    send_word(d, lsb);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (sout !== seq[7-i] || sout_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_bit%0d: got sout=%b sv=%b want sout=%b sv=1",
                 name, i, sout, sout_valid, seq[7-i]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got done=%b rdy=%b want done=1 rdy=0", name, done, din_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: got done=%b rdy=%b want done=0 rdy=1", name, done, din_ready);
    end
    $display("test_shift_order %s din=%h lsb=%b done", name, d, lsb);
  endtask

  task automatic test_stall();
    logic [11:0] en_pat;
    logic [7:0]  seq;
    int idx;
    en_pat = 12'b1001_1101_1011;
    seq = 8'b1100_0011;
    idx = 0;
    do_reset();
    shift_en = 1'b1;
    send_word(8'hC3, 1'b0);
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (sout !== seq[7-idx] || sout_valid !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cyc%0d: got sout=%b sv=%b done=%b want sout=%b sv=1 done=0",
                 c, sout, sout_valid, done, seq[7-idx]);
      end
      shift_en = en_pat[11-c];
      tick();
      if (en_pat[11-c]) idx++;
    end
    shift_en = 1'b1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_done: got done=%b want 1 after 4 stalls", done);
    end
    $display("test_stall din=c3 done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    shift_en = 1'b1;
    send_word(8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (sout0 !== 1'b1 || sout_valid0 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_w0_bit%0d: got sout=%b sv=%b want 1 1", i, sout0, sout_valid0);
      end
      tick();
    end
    n_checks++;
    if (done0 !== 1'b1 || din_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_coincident0: got done=%b rdy=%b want 1 1", done0, din_ready0);
    end
    send_word(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (sout0 !== 1'b0 || sout_valid0 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_w1_bit%0d: got sout=%b sv=%b want 0 1", i, sout0, sout_valid0);
      end
      tick();
    end
    n_checks++;
    if (done0 !== 1'b1 || din_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_coincident1: got done=%b rdy=%b want 1 1", done0, din_ready0);
    end
    $display("test_back_to_back ff,00 done");
  endtask

  task automatic test_clr_mid();
    logic [7:0] seq;
    seq = 8'b1000_0001;
    do_reset();
    shift_en = 1'b1;
    send_word(8'hF0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (sout !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_pre_bit%0d: got sout=%b want 1", i, sout);
      end
      tick();
    end
    clr = 1'b1;
    #1;
    n_checks++;
    if ({sout, sout_valid, busy, din_ready, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL clr_async: got sout/sv/busy/rdy/done=%b want 00000",
               {sout, sout_valid, busy, din_ready, done});
    end
    tick();
    clr = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || din_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_recover: got done=%b rdy=%b busy=%b want 0 1 0", done, din_ready, busy);
    end
    send_word(8'h81, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (sout !== seq[7-i] || sout_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_next_bit%0d: got sout=%b sv=%b want %b 1",
                 i, sout, sout_valid, seq[7-i]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_next_done: got %b want 1", done);
    end
    $display("test_clr_mid f0 then 81 done");
  endtask

  task automatic test_busy_hold();
    logic [7:0] seq;
    seq = 8'b0011_1100;
    do_reset();
    shift_en = 1'b1;
    din = 8'h3C;
    lsb_first = 1'b0;
    din_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      din = din + 8'h11;
      n_checks++;
      if (sout !== seq[7-i] || busy !== 1'b1 || din_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_bit%0d: got sout=%b busy=%b rdy=%b want %b 1 0",
                 i, sout, busy, din_ready, seq[7-i]);
      end
      tick();
    end
    din = 8'h55;
    n_checks++;
    if (done !== 1'b1 || sout_valid !== 1'b0 || busy !== 1'b1 || din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_gap: got done=%b sv=%b busy=%b rdy=%b want 1 0 1 0",
               done, sout_valid, busy, din_ready);
    end
    din = 8'h96;
    tick();
    n_checks++;
    if (din_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ready: got rdy=%b busy=%b want 1 0", din_ready, busy);
    end
    tick();
    din_valid = 1'b0;
    n_checks++;
    if (sout !== 1'b1 || sout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_second_b0: got sout=%b sv=%b want 1 1", sout, sout_valid);
    end
    tick();
    n_checks++;
    if (sout !== 1'b0 || sout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_second_b1: got sout=%b sv=%b want 0 1", sout, sout_valid);
    end
    $display("test_busy_hold 3c then 96 done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shift_order("msb_a5", 8'hA5, 1'b0, 8'b1010_0101);
    test_shift_order("lsb_a5", 8'hA5, 1'b1, 8'b1010_0101);
    test_shift_order("lsb_01", 8'h01, 1'b1, 8'b1000_0000);
    test_stall();
    test_back_to_back();
    test_clr_mid();
    test_busy_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
